// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory-stage controller.
// Holds the FSM state enum, RV32 load/store func3 codes, the default
// access timeout and the packed payloads latched for a memory access
// and registered towards MEM/WB.
package mem_stage_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned F3_W   = 3;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_e;

   localparam logic [F3_W-1:0] FUNC3_LB  = 3'b000;
   localparam logic [F3_W-1:0] FUNC3_LH  = 3'b001;
   localparam logic [F3_W-1:0] FUNC3_LW  = 3'b010;
   localparam logic [F3_W-1:0] FUNC3_LBU = 3'b100;
   localparam logic [F3_W-1:0] FUNC3_LHU = 3'b101;
   localparam logic [F3_W-1:0] FUNC3_SB  = 3'b000;
   localparam logic [F3_W-1:0] FUNC3_SH  = 3'b001;
   localparam logic [F3_W-1:0] FUNC3_SW  = 3'b010;

   // Access captured at acceptance and replayed to the data memory.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [F3_W-1:0]   func3;
      logic [REG_W-1:0]  rd;
      logic              reg_write;
      logic              is_load;
   } mem_req_t;

   // MEM/WB result register.
   typedef struct packed {
      logic              valid;
      logic              misaligned;
      logic              mem_error;
      logic              reg_write;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } mem_wb_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Bus bundle for the memory-stage controller.
// Upstream side: In_valid/In_ready handshake plus instruction payload.
// Memory side:   Mem_read/Mem_write pulses, address/data/func3, busywait.
// Downstream:    Stall and the MEM/WB result (Wb_*, Misaligned, Mem_error).
// modport master is the controller, modport slave is its environment.
interface mem_stage_ctrl_if;
   import mem_stage_pkg::*;

   logic              In_valid;
   logic              In_ready;
   logic              In_load;
   logic              In_store;
   logic [F3_W-1:0]   In_func3;
   logic [ADDR_W-1:0] In_address;
   logic [DATA_W-1:0] In_store_data;
   logic [REG_W-1:0]  In_rd;
   logic              In_reg_write;

   logic              Mem_read;
   logic              Mem_write;
   logic [ADDR_W-1:0] Mem_address;
   logic [DATA_W-1:0] Mem_write_data;
   logic [F3_W-1:0]   Mem_func3;
   logic [DATA_W-1:0] Mem_read_data;
   logic              Mem_busywait;

   logic              Stall;
   logic              Wb_valid;
   logic [REG_W-1:0]  Wb_rd;
   logic [DATA_W-1:0] Wb_data;
   logic              Wb_reg_write;
   logic              Misaligned;
   logic              Mem_error;

   modport master (
      input  In_valid, In_load, In_store, In_func3, In_address, In_store_data,
             In_rd, In_reg_write, Mem_read_data, Mem_busywait,
      output In_ready, Mem_read, Mem_write, Mem_address, Mem_write_data,
             Mem_func3, Stall, Wb_valid, Wb_rd, Wb_data, Wb_reg_write,
             Misaligned, Mem_error
   );

   modport slave (
      output In_valid, In_load, In_store, In_func3, In_address, In_store_data,
             In_rd, In_reg_write, Mem_read_data, Mem_busywait,
      input  In_ready, Mem_read, Mem_write, Mem_address, Mem_write_data,
             Mem_func3, Stall, Wb_valid, Wb_rd, Wb_data, Wb_reg_write,
             Misaligned, Mem_error
   );

endinterface

// File: rtl/mem_stage_ctrl_align_check.sv
// Combinational alignment check for RV32 loads/stores.
// Ports: func3_i (width code), addr_lsb_i (address bits [1:0]),
//        misaligned_c_o (1 = access cannot be issued).
// Undefined width codes report misaligned so they never reach memory.
module mem_align_check
   import mem_stage_pkg::*;
(
   input  logic [F3_W-1:0] func3_i,
   input  logic [1:0]      addr_lsb_i,
   output logic            misaligned_c_o
);

   always_comb begin
      misaligned_c_o = 1'b1;
      case (func3_i)
         FUNC3_LB, FUNC3_LBU: misaligned_c_o = 1'b0;
         FUNC3_LH, FUNC3_LHU: misaligned_c_o = addr_lsb_i[0];
         FUNC3_LW:            misaligned_c_o = |addr_lsb_i;
         default:             misaligned_c_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller between EX/MEM and the data memory.
// Ports: Clock, Reset (async, active-high), bus (mem_stage_ctrl_if.master).
// ALU ops retire in one cycle; aligned loads/stores issue a one-cycle
// Mem_read/Mem_write pulse, follow busywait high then low, and retire with
// a registered MEM/WB result. Misaligned ops and timeouts retire with a flag.
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input logic              Clock,
   input logic              Reset,
   mem_stage_ctrl_if.master bus
);

   localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   mem_req_t         req_q, req_d;
   mem_wb_t          wb_q, wb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;

   logic             misaligned_c;
   logic             is_mem_c;
   logic             timeout_c;

   mem_align_check u_align (
      .func3_i        (bus.In_func3),
      .addr_lsb_i     (bus.In_address[1:0]),
      .misaligned_c_o (misaligned_c)
   );

   assign is_mem_c  = bus.In_load | bus.In_store;
   assign timeout_c = (cnt_q == CNT_LAST);

   // Next-state, latch capture and MEM/WB result.
   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      cnt_d          = cnt_q;
      wb_d           = wb_q;
      wb_d.valid     = 1'b0;
      wb_d.misaligned = 1'b0;
      wb_d.mem_error = 1'b0;
      mem_read_d     = 1'b0;
      mem_write_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.In_valid) begin
               if (!is_mem_c) begin
                  wb_d.valid     = 1'b1;
                  wb_d.data      = bus.In_address;
                  wb_d.rd        = bus.In_rd;
                  wb_d.reg_write = bus.In_reg_write;
               end else if (misaligned_c) begin
                  wb_d.valid      = 1'b1;
                  wb_d.misaligned = 1'b1;
                  wb_d.rd         = bus.In_rd;
                  wb_d.reg_write  = 1'b0;
               end else begin
                  // Store wins when both flags are set.
                  req_d.addr      = bus.In_address;
                  req_d.wdata     = bus.In_store_data;
                  req_d.func3     = bus.In_func3;
                  req_d.rd        = bus.In_rd;
                  req_d.reg_write = bus.In_reg_write;
                  req_d.is_load   = !bus.In_store;
                  cnt_d           = '0;
                  mem_read_d      = !bus.In_store;
                  mem_write_d     = bus.In_store;
                  state_d         = ST_REQ;
               end
            end
         end
         ST_REQ: state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY, ST_WAIT_DONE: begin
            if (timeout_c) begin
               wb_d.valid     = 1'b1;
               wb_d.mem_error = 1'b1;
               wb_d.rd        = req_q.rd;
               wb_d.reg_write = 1'b0;
               state_d        = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (state_q == ST_WAIT_BUSY) begin
                  if (bus.Mem_busywait) state_d = ST_WAIT_DONE;
               end else if (!bus.Mem_busywait) begin
                  wb_d.valid     = 1'b1;
                  wb_d.rd        = req_q.rd;
                  wb_d.reg_write = req_q.is_load & req_q.reg_write;
                  if (req_q.is_load) wb_d.data = bus.Mem_read_data;
                  state_d        = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         wb_q        <= '0;
         cnt_q       <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         wb_q        <= wb_d;
         cnt_q       <= cnt_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   assign bus.In_ready       = (state_q == ST_IDLE);
   assign bus.Stall          = (state_q != ST_IDLE);
   assign bus.Mem_read       = mem_read_q;
   assign bus.Mem_write      = mem_write_q;
   assign bus.Mem_address    = req_q.addr;
   assign bus.Mem_write_data = req_q.wdata;
   assign bus.Mem_func3      = req_q.func3;
   assign bus.Wb_valid       = wb_q.valid;
   assign bus.Wb_rd          = wb_q.rd;
   assign bus.Wb_data        = wb_q.data;
   assign bus.Wb_reg_write   = wb_q.reg_write;
   assign bus.Misaligned     = wb_q.misaligned;
   assign bus.Mem_error      = wb_q.mem_error;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed table, hand-written
// multi-cycle sequences and randomized ops against a reference model.
module tb_mem_stage_ctrl;
   import mem_stage_pkg::*;

   localparam int unsigned TO_MAIN = 64;
   localparam int unsigned TO_SMALL = 8;

   logic Clock;
   logic Reset;
   int   n_cmp;
   int   n_fail;
   int unsigned mem_lat;

   mem_stage_ctrl_if m ();
   mem_stage_ctrl_if mt ();

   mem_stage_ctrl #(.TIMEOUT_CYCLES(TO_MAIN)) dut (.Clock(Clock), .Reset(Reset), .bus(m));
   mem_stage_ctrl #(.TIMEOUT_CYCLES(TO_SMALL)) dut_to (.Clock(Clock), .Reset(Reset), .bus(mt));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] addr, wdata;
      logic [4:0]  rd;
      logic        rw;
      int unsigned nbusy;
      int unsigned e_lat;
      logic        e_mis, e_err, e_rw, chk_data;
      logic [31:0] e_data;
      int unsigned e_rdp, e_wrp;
   } vec_t;

   // Word-granular memories: env_mem is what the memory holds, ref_mem
   // is the reference model's own record of completed stores.
   logic [31:0] env_mem [logic [29:0]];
   logic [31:0] ref_mem [logic [29:0]];
   int unsigned env_rem;

   function automatic logic [31:0] dflt(input logic [29:0] k);
      return ~{k, 2'b00};
   endfunction

   function automatic logic [31:0] env_rd(input logic [31:0] a);
      return env_mem.exists(a[31:2]) ? env_mem[a[31:2]] : dflt(a[31:2]);
   endfunction

   // Data memory: busywait rises on the edge that sees a request and stays
   // high mem_lat cycles; mem_lat of 0 means busywait never rises.
   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         m.Mem_busywait  <= 1'b0;
         m.Mem_read_data <= '0;
         env_rem         <= 0;
      end else if (m.Mem_read || m.Mem_write) begin
         if (m.Mem_write) env_mem[m.Mem_address[31:2]] = m.Mem_write_data;
         m.Mem_read_data <= env_rd(m.Mem_address);
         m.Mem_busywait  <= (mem_lat != 0);
         env_rem         <= (mem_lat != 0) ? mem_lat - 1 : 0;
      end else if (env_rem != 0) begin
         env_rem <= env_rem - 1;
      end else begin
         m.Mem_busywait <= 1'b0;
      end
   end

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic vec_t mk(input logic ld, st, input logic [2:0] f3, input logic [31:0] addr, wdata,
                               input logic [4:0] rd, input logic rw, input int unsigned nb, lat,
                               input logic mis, err, erw, cd, input logic [31:0] ed, input int unsigned rdp, wrp);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rw = rw;
      v.nbusy = nb; v.e_lat = lat; v.e_mis = mis; v.e_err = err; v.e_rw = erw; v.chk_data = cd;
      v.e_data = ed; v.e_rdp = rdp; v.e_wrp = wrp;
      return v;
   endfunction

   // Reference: expected retirement from the instruction and memory delay.
   // Latency counts edges after the accepting edge; a delay of N busy
   // cycles retires N+2 edges later unless the timeout fires first.
   function automatic vec_t ref_calc(input vec_t v);
      vec_t r;
      int size;
      bit mis;
      bit undef;
      r = v;
      r.e_lat = 0; r.e_mis = 0; r.e_err = 0; r.e_rw = 0; r.chk_data = 0;
      r.e_data = '0; r.e_rdp = 0; r.e_wrp = 0;
      undef = 0; size = 1;
      case (v.f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    undef = 1;
      endcase
      mis = undef || ((int'(v.addr[1:0]) % size) != 0);
      if (!(v.ld || v.st)) begin
         r.e_rw = v.rw; r.chk_data = 1; r.e_data = v.addr;
      end else if (mis) begin
         r.e_mis = 1;
      end else begin
         if (v.st) r.e_wrp = 1; else r.e_rdp = 1;
         if (v.nbusy == 0 || v.nbusy >= TO_MAIN - 1) begin
            r.e_lat = TO_MAIN + 1; r.e_err = 1;
         end else begin
            r.e_lat = v.nbusy + 2;
            if (v.st) ref_mem[v.addr[31:2]] = v.wdata;
            else begin
               r.e_rw = v.rw; r.chk_data = 1;
               r.e_data = ref_mem.exists(v.addr[31:2]) ? ref_mem[v.addr[31:2]] : dflt(v.addr[31:2]);
            end
         end
      end
      return r;
   endfunction

   task automatic drive_idle();
      m.In_valid = 0; m.In_load = 0; m.In_store = 0; m.In_func3 = 0;
      m.In_address = 0; m.In_store_data = 0; m.In_rd = 0; m.In_reg_write = 0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_addr_wdata"}, {m.Mem_address, m.Mem_write_data}, 64'd0);
      chk({tag, "_ctrl"}, 64'({m.Wb_data, m.Mem_func3, m.Wb_rd, m.Mem_read, m.Mem_write, m.Stall,
                                m.Wb_valid, m.Wb_reg_write, m.Misaligned, m.Mem_error}), 64'd0);
      chk({tag, "_in_ready"}, 64'(m.In_ready), 64'd1);
   endtask

   task automatic run_op(input vec_t v);
      int unsigned cyc, stall_n, rdp, wrp;
      logic [31:0] a0, wd0;
      logic [2:0]  f0;
      bit moved;
      chk("in_ready", 64'(m.In_ready), 64'd1);
      m.In_valid = 1; m.In_load = v.ld; m.In_store = v.st; m.In_func3 = v.f3;
      m.In_address = v.addr; m.In_store_data = v.wdata; m.In_rd = v.rd; m.In_reg_write = v.rw;
      mem_lat = v.nbusy;
      tick();
      m.In_valid = 0; m.In_load = 1'($urandom); m.In_store = 1'($urandom); m.In_func3 = 3'($urandom);
      m.In_address = $urandom; m.In_store_data = $urandom; m.In_rd = 5'($urandom); m.In_reg_write = 1'($urandom);
      cyc = 0; stall_n = 0; rdp = 0; wrp = 0; moved = 0;
      a0 = m.Mem_address; wd0 = m.Mem_write_data; f0 = m.Mem_func3;
      while (!m.Wb_valid && cyc < 400) begin
         if (m.Stall) stall_n++;
         if (m.Mem_read) rdp++;
         if (m.Mem_write) wrp++;
         if (m.Mem_address !== a0 || m.Mem_write_data !== wd0 || m.Mem_func3 !== f0) moved = 1;
         tick();
         cyc++;
      end
      chk("latency", 64'(cyc), 64'(v.e_lat));
      chk("stall_cycles", 64'(stall_n), 64'(v.e_lat));
      chk("stall_at_wb", 64'(m.Stall), 64'd0);
      chk("read_pulses", 64'(rdp), 64'(v.e_rdp));
      chk("write_pulses", 64'(wrp), 64'(v.e_wrp));
      chk("misaligned", 64'(m.Misaligned), 64'(v.e_mis));
      chk("mem_error", 64'(m.Mem_error), 64'(v.e_err));
      chk("wb_reg_write", 64'(m.Wb_reg_write), 64'(v.e_rw));
      if (v.chk_data) begin
         chk("wb_data", 64'(m.Wb_data), 64'(v.e_data));
         chk("wb_rd", 64'(m.Wb_rd), 64'(v.rd));
      end
      if (v.e_rdp + v.e_wrp != 0) begin
         chk("mem_addr_stable", 64'(moved), 64'd0);
         chk("mem_address", 64'(a0), 64'(v.addr));
         chk("mem_func3", 64'(f0), 64'(v.f3));
         if (v.st) chk("mem_write_data", 64'(wd0), 64'(v.wdata));
      end
      tick();
      chk("wb_one_cycle", 64'({m.Wb_valid, m.Misaligned, m.Mem_error}), 64'd0);
   endtask

   vec_t tbl [15];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int unsigned cyc, nwb, kind;
      n_cmp = 0; n_fail = 0; mem_lat = 1;
      drive_idle();
      mt.In_valid = 0; mt.In_load = 0; mt.In_store = 0; mt.In_func3 = 0; mt.In_address = 0;
      mt.In_store_data = 0; mt.In_rd = 0; mt.In_reg_write = 0; mt.Mem_busywait = 0; mt.Mem_read_data = 0;

      Reset = 0;
      #2 Reset = 1;
      #2 check_zero("reset");
      tick(); tick();
      Reset = 0;
      tick();

      tbl[0]  = mk(0,0,3'd0,    32'h1234,     0,            5, 1, 1,  0, 0,0,1,1, 32'h1234,     0,0);
      tbl[1]  = mk(0,1,FUNC3_SW,32'h40,       32'hDEADBEEF, 3, 1, 1,  3, 0,0,0,0, 0,            0,1);
      tbl[2]  = mk(1,0,FUNC3_LW,32'h40,       0,            7, 1, 1,  3, 0,0,1,1, 32'hDEADBEEF, 1,0);
      tbl[3]  = mk(1,0,FUNC3_LH,32'h43,       0,            9, 1, 1,  0, 1,0,0,0, 0,            0,0);
      tbl[4]  = mk(1,0,FUNC3_LB,32'h43,       0,           10, 1, 1,  3, 0,0,1,1, 32'hDEADBEEF, 1,0);
      tbl[5]  = mk(1,0,FUNC3_LW,32'h40,       0,           12, 1,10, 12, 0,0,1,1, 32'hDEADBEEF, 1,0);
      tbl[6]  = mk(1,0,3'b011,  32'h40,       0,           13, 1, 1,  0, 1,0,0,0, 0,            0,0);
      tbl[7]  = mk(1,1,FUNC3_SH,32'h82,       32'h0000CAFE,14, 1, 2,  4, 0,0,0,0, 0,            0,1);
      tbl[8]  = mk(1,0,FUNC3_LW,32'h80,       0,            1, 1, 3,  5, 0,0,1,1, 32'h0000CAFE, 1,0);
      tbl[9]  = mk(1,0,FUNC3_LW,32'h44,       0,           15, 1, 0, 65, 0,1,0,0, 0,            1,0);
      tbl[10] = mk(0,0,3'b111,  32'hFFFFFFFF, 0,           31, 0, 1,  0, 0,0,0,1, 32'hFFFFFFFF, 0,0);
      tbl[11] = mk(1,0,FUNC3_LHU,32'h46,      0,           16, 1,62, 64, 0,0,1,1, 32'hFFFFFFBB, 1,0);
      tbl[12] = mk(1,0,FUNC3_LW,32'h44,       0,           17, 1,63, 65, 0,1,0,0, 0,            1,0);
      tbl[13] = mk(0,1,FUNC3_SW,32'h41,       32'h12345678, 2, 1, 1,  0, 1,0,0,0, 0,            0,0);
      tbl[14] = mk(1,0,FUNC3_LW,32'h44,       0,           18, 0, 1,  3, 0,0,0,1, 32'hFFFFFFBB, 1,0);
      for (int i = 0; i < 15; i++) run_op(tbl[i]);

      // Back-to-back: accept in the Wb_valid cycle, then two ALU ops in a row.
      mem_lat = 1;
      m.In_valid = 1; m.In_load = 1; m.In_store = 0; m.In_func3 = FUNC3_LW;
      m.In_address = 32'h80; m.In_rd = 2; m.In_reg_write = 1;
      tick();
      m.In_valid = 0;
      tick(); tick(); tick();
      chk("b2b_load_valid", 64'(m.Wb_valid), 64'd1);
      chk("b2b_load_data", 64'(m.Wb_data), 64'h0000CAFE);
      chk("b2b_ready", 64'(m.In_ready), 64'd1);
      m.In_valid = 1; m.In_load = 0; m.In_address = 32'h5555; m.In_rd = 4;
      tick();
      chk("b2b_alu1", 64'({m.Wb_valid, m.Wb_rd, m.Wb_data}), 64'({1'b1, 5'd4, 32'h5555}));
      m.In_address = 32'h6666; m.In_rd = 6;
      tick();
      chk("b2b_alu2", 64'({m.Wb_valid, m.Wb_rd, m.Wb_data}), 64'({1'b1, 5'd6, 32'h6666}));
      m.In_valid = 0;
      tick();
      chk("b2b_idle", 64'(m.Wb_valid), 64'd0);

      // Reset while waiting for busywait to fall.
      mem_lat = 10;
      m.In_valid = 1; m.In_load = 1; m.In_store = 0; m.In_func3 = FUNC3_LW;
      m.In_address = 32'h40; m.In_rd = 7; m.In_reg_write = 1;
      tick();
      m.In_valid = 0;
      tick(); tick(); tick();
      chk("pre_reset_stall", 64'(m.Stall), 64'd1);
      #2 Reset = 1;
      #1 check_zero("mid_reset");
      tick();
      Reset = 0;
      nwb = 0;
      for (int i = 0; i < 20; i++) begin
         if (m.Wb_valid) nwb++;
         tick();
      end
      chk("no_wb_after_reset", 64'(nwb), 64'd0);
      run_op(mk(1,0,FUNC3_LW,32'h40,0,7,1,2, 4,0,0,1,1,32'hDEADBEEF,1,0));

      // Busywait never rises on the small-timeout instance.
      mt.In_valid = 1; mt.In_load = 1; mt.In_func3 = FUNC3_LW; mt.In_address = 32'h80;
      mt.In_rd = 3; mt.In_reg_write = 1;
      tick();
      mt.In_valid = 0;
      cyc = 0;
      while (!mt.Wb_valid && cyc < 50) begin tick(); cyc++; end
      chk("to8_latency", 64'(cyc), 64'(TO_SMALL + 1));
      chk("to8_flags", 64'({mt.Mem_error, mt.Misaligned, mt.Wb_reg_write}), 64'b100);
      tick();
      chk("to8_one_cycle", 64'({mt.Wb_valid, mt.Mem_error, mt.In_ready}), 64'b001);

      // Randomized ops in a region the directed table does not touch.
      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 3);
         v.ld = (kind == 1 || kind == 3);
         v.st = (kind == 2 || kind == 3);
         v.f3 = 3'($urandom_range(0, 7));
         if (kind == 0) v.addr = $urandom;
         else begin
            v.addr = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
         end
         v.wdata = $urandom;
         v.rd = 5'($urandom_range(0, 31));
         v.rw = 1'($urandom_range(0, 1));
         v.nbusy = $urandom_range(1, 12);
         run_op(ref_calc(v));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller between the EX/MEM pipeline register and the data memory. It accepts one instruction at a time and passes ALU-only instructions straight through. For a load or store it runs the single-pulse Read/Write + busywait handshake with the data memory, stalls upstream while the access is in flight, and delivers a registered MEM/WB result. It also detects misaligned accesses and memory timeouts.

## Interface
- TIMEOUT_CYCLES, 64: maximum number of cycles spent in WAIT_BUSY plus WAIT_DONE before the access is abandoned.
- Clock  in  1  system clock, all state changes on posedge.
- Reset  in  1  asynchronous, active-high.
- In_valid  in  1  EX/MEM holds a valid instruction.
- In_ready  out  1  unit can accept an instruction; upstream holds its payload while this is low.
- In_load / In_store  in  1  instruction is a load or a store; both high is treated as a store.
- In_func3  in  3  RV32 load/store width code.
- In_address  in  32  effective address, which is the ALU result.
- In_store_data  in  32  rs2 value.
- In_rd  in  5  destination register.
- In_reg_write  in  1  instruction writes rd.
- Mem_read / Mem_write  out  1  one-cycle request pulse to the data memory.
- Mem_address  out  32  address to the data memory.
- Mem_write_data  out  32  store data to the data memory.
- Mem_func3  out  3  width code to the data memory.
- Mem_read_data  in  32  load data from memory, already extended.
- Mem_busywait  in  1  memory busy indication.
- Stall  out  1  high whenever the state is not IDLE.
- Wb_valid  out  1  one-cycle pulse; MEM/WB fields are valid.
- Wb_rd  out  5  MEM/WB destination register.
- Wb_data  out  32  MEM/WB result data.
- Wb_reg_write  out  1  MEM/WB register-write enable.
- Misaligned  out  1  one-cycle pulse, coincident with Wb_valid.
- Mem_error  out  1  one-cycle pulse on timeout, coincident with Wb_valid.

## Operation
- States: IDLE, REQ, WAIT_BUSY, WAIT_DONE.
- In_ready = (state == IDLE). Stall = !In_ready.
- **IDLE, In_valid, neither load nor store:** next edge registers Wb_valid=1, Wb_data=In_address, Wb_rd, and Wb_reg_write=In_reg_write. State stays IDLE.
- **IDLE, load/store, aligned:** latch address, store data, func3, rd, reg_write and the load flag. Go to REQ.
- **IDLE, load/store, misaligned:** no memory access. Next edge pulses Wb_valid and Misaligned, with Wb_reg_write=0. State stays IDLE.
  - Halfword (func3 001/101) is misaligned when addr[0]=1.
  - Word (func3 010) is misaligned when addr[1:0]≠0.
  - Byte accesses are never misaligned.
  - Undefined func3 (011/110/111) counts as misaligned.
- **REQ:** drive Mem_read (load) or Mem_write (store) high for exactly this cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** requests low. On Mem_busywait=1, go to WAIT_DONE.
- **WAIT_DONE:** on Mem_busywait=0, register the result and return to IDLE.
  - Load: Wb_data = Mem_read_data, Wb_reg_write = latched reg_write.
  - Store: Wb_reg_write=0.
  - Wb_valid pulses in both cases.
- Mem_address, Mem_write_data and Mem_func3 come from the latch registers. They hold stable from REQ through the WAIT_DONE exit edge, and keep their last value in IDLE.
- **Timeout:** a counter clears on entering REQ and increments in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES-1, the next edge pulses Wb_valid and Mem_error, sets Wb_reg_write=0, and returns to IDLE. The counter width is clog2(TIMEOUT_CYCLES).
- Wb_valid, Misaligned and Mem_error are high for exactly one cycle per accepted instruction, never more.

## Timing
- **Reset (asynchronous):** state=IDLE. All outputs 0, including Mem_address, Mem_write_data, Wb_data, Wb_rd and Mem_func3. Counter=0.
- **Reset mid-access:** the access is abandoned with no Wb_valid. The memory's own reset clears its handshake state.
- **Pass-through latency:** 1 cycle from acceptance to Wb_valid.
- **Misaligned latency:** 1 cycle from acceptance to Wb_valid and Misaligned.
- **Load/store latency, single-cycle-busy memory:** accept edge E0 → REQ. E1 → WAIT_BUSY, busywait rises. E2 → WAIT_DONE, busywait falls. E3 → Wb_valid. Total: 3 cycles, with Stall high for the 3 cycles after E0.
- **Slower memory:** latency is 3 + extra busywait cycles.
- **Back-to-back:** a new instruction can be accepted in the cycle immediately after Wb_valid is registered.
- **Busywait already high on REQ exit:** WAIT_BUSY is left on the first edge.
- **Busywait never rising:** ends in timeout.

## Structure
- Package mem_stage_pkg holds:
  - the state enum;
  - FUNC3 constants LB, LH, LW, LBU, LHU, SB, SH, SW;
  - the default TIMEOUT_CYCLES.
- Sub-module mem_align_check is combinational: (func3, addr[1:0]) → misaligned. It is shared with the future decode-time checker.

## Test plan
- **ALU pass-through:** In_valid, In_load=0, In_address=0x0000_1234, rd=5, reg_write=1 → next cycle Wb_valid=1, Wb_data=0x1234, Wb_rd=5, Stall never high.
- **SW then LW:** SW of 0xDEAD_BEEF to 0x40, then LW from 0x40, rd=7.
  - Each access: Mem_write/Mem_read is a single one-cycle pulse and Stall is high for 3 cycles.
  - SW retire: Wb_reg_write=0.
  - LW retire: Wb_data=0xDEAD_BEEF, Wb_rd=7.
- **LH at 0x43** → no Mem_read pulse; next cycle Misaligned=1, Wb_valid=1, Wb_reg_write=0. **LB at 0x43** proceeds normally.
- **Model holds busywait high 10 cycles:** Mem_address stays constant throughout, Wb_valid arrives at cycle 12. **Busywait stuck low, TIMEOUT_CYCLES=8:** Mem_error and Wb_valid pulse at cycle 9 after acceptance.
- **Reset asserted asynchronously in WAIT_DONE:** all outputs 0 immediately, no Wb_valid after release, next load completes correctly.
